// File: rtl/modulo_mux_scan.sv
// Registered N:1 mux with inverted select mapping, plus an auto-scan mode that
// dwells DWELL enabled cycles on each channel and wraps at N_INPUTS-1.
module modulo_mux_scan #(
    parameter int N_INPUTS = 16,
    parameter int SEL_W    = 4,
    parameter int DWELL    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_INPUTS-1:0] input_e,
    input  logic [SEL_W-1:0]    input_sel,
    input  logic                mode,
    input  logic                enable,
    input  logic                load,
    output logic                out,
    output logic [SEL_W-1:0]    cur_sel,
    output logic                valid,
    output logic                wrap,
    output logic                sel_err
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] MANUAL = 2'd1;
    localparam logic [1:0] SCAN   = 2'd2;

    localparam int              CNT_W      = 8;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] LAST_SEL   = SEL_W'(N_INPUTS - 1);
    localparam logic [SEL_W:0]   N_LIMIT    = (SEL_W + 1)'(N_INPUTS);

    logic [1:0]           state;
    logic [CNT_W-1:0]     dwell_cnt;
    logic [2**SEL_W-1:0]  e_pad;
    logic [SEL_W-1:0]     sample_idx;
    logic                 sample_bit;
    logic                 sel_ok;
    logic                 take_sel;
    logic [CNT_W-1:0]     eff_cnt;
    logic                 dwell_done;
    logic                 at_last;

    // Reverse the inputs once so index k reads input_e[N-1-k]; slots past
    // N_INPUTS read as 0, which gives out=0 for an out-of-range index for free.
    for (genvar g = 0; g < 2**SEL_W; g++) begin : g_map
        if (g < N_INPUTS) begin : g_in
            assign e_pad[g] = input_e[N_INPUTS-1-g];
        end else begin : g_pad
            assign e_pad[g] = 1'b0;
        end
    end

    // Manual mode and scan loads sample input_sel; free-running scan samples the pointer.
    assign take_sel   = !mode || load;
    assign sample_idx = take_sel ? input_sel : cur_sel;
    assign sample_bit = e_pad[sample_idx];
    assign sel_ok     = {1'b0, sample_idx} < N_LIMIT;

    // Arriving in SCAN from any other state starts a fresh dwell on the kept pointer.
    assign eff_cnt    = (state == SCAN) ? dwell_cnt : '0;
    assign dwell_done = eff_cnt == DWELL_LAST;
    assign at_last    = cur_sel >= LAST_SEL;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            out       <= 1'b0;
            cur_sel   <= '0;
            dwell_cnt <= '0;
            valid     <= 1'b0;
            wrap      <= 1'b0;
            sel_err   <= 1'b0;
        end else if (!enable) begin
            valid <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            state   <= mode ? SCAN : MANUAL;
            valid   <= 1'b1;
            wrap    <= 1'b0;
            out     <= sample_bit;
            sel_err <= !sel_ok;
            if (take_sel) begin
                cur_sel   <= input_sel;
                dwell_cnt <= '0;
            end else if (dwell_done) begin
                dwell_cnt <= '0;
                // A pointer parked out of range by a load also returns to 0.
                if (at_last) begin
                    cur_sel <= '0;
                    wrap    <= 1'b1;
                end else begin
                    cur_sel <= cur_sel + 1'b1;
                end
            end else begin
                dwell_cnt <= eff_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_modulo_mux_scan.sv
// Bench for modulo_mux_scan: three configurations (16/DWELL4, 10/DWELL2, 16/DWELL1)
// driven in lockstep, each tracked by its own reference model.
module tb_modulo_mux_scan;

    logic        clk = 1'b0;
    logic        rst, en, md, ld;
    logic [3:0]  sel;
    logic [15:0] e;

    logic       o_a, v_a, w_a, er_a;
    logic [3:0] c_a;
    logic       o_b, v_b, w_b, er_b;
    logic [3:0] c_b;
    logic       o_c, v_c, w_c, er_c;
    logic [3:0] c_c;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    modulo_mux_scan #(.N_INPUTS(16), .SEL_W(4), .DWELL(4)) dut_a (
        .clk(clk), .reset(rst), .input_e(e), .input_sel(sel), .mode(md),
        .enable(en), .load(ld), .out(o_a), .cur_sel(c_a), .valid(v_a),
        .wrap(w_a), .sel_err(er_a));

    modulo_mux_scan #(.N_INPUTS(10), .SEL_W(4), .DWELL(2)) dut_b (
        .clk(clk), .reset(rst), .input_e(e[9:0]), .input_sel(sel), .mode(md),
        .enable(en), .load(ld), .out(o_b), .cur_sel(c_b), .valid(v_b),
        .wrap(w_b), .sel_err(er_b));

    modulo_mux_scan #(.N_INPUTS(16), .SEL_W(4), .DWELL(1)) dut_c (
        .clk(clk), .reset(rst), .input_e(e), .input_sel(sel), .mode(md),
        .enable(en), .load(ld), .out(o_c), .cur_sel(c_c), .valid(v_c),
        .wrap(w_c), .sel_err(er_c));

    // Reference models: channel pointer, cycles spent on it (1..dwell), last sample.
    int n_cfg[3]  = '{16, 10, 16};
    int dw_cfg[3] = '{4, 2, 1};
    int m_sel[3], m_spent[3], m_out[3], m_valid[3], m_wrap[3], m_err[3];
    bit m_scanning[3];

    task automatic model_reset();
        for (int j = 0; j < 3; j++) begin
            m_sel[j] = 0; m_spent[j] = 0; m_out[j] = 0;
            m_valid[j] = 0; m_wrap[j] = 0; m_err[j] = 0; m_scanning[j] = 0;
        end
    endtask

    task automatic model_step(input int j);
        int idx;
        int n;
        n = n_cfg[j];
        if (rst) begin
            m_sel[j] = 0; m_spent[j] = 0; m_out[j] = 0;
            m_valid[j] = 0; m_wrap[j] = 0; m_err[j] = 0; m_scanning[j] = 0;
        end else if (!en) begin
            m_valid[j] = 0;
            m_wrap[j]  = 0;
        end else begin
            m_valid[j] = 1;
            m_wrap[j]  = 0;
            if (!md || ld) begin
                idx = int'(sel);
                m_sel[j] = idx;
                m_spent[j] = 0;
            end else begin
                idx = m_sel[j];
                if (!m_scanning[j]) m_spent[j] = 0;
                m_spent[j]++;
                if (m_spent[j] == dw_cfg[j]) begin
                    m_spent[j] = 0;
                    if (m_sel[j] >= n - 1) begin
                        m_sel[j] = 0;
                        m_wrap[j] = 1;
                    end else begin
                        m_sel[j]++;
                    end
                end
            end
            m_scanning[j] = md;
            m_err[j] = (idx >= n);
            m_out[j] = (idx < n) ? int'(e[n-1-idx]) : 0;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_models();
        chk("a_out", int'(o_a), m_out[0]);   chk("a_cur", int'(c_a), m_sel[0]);
        chk("a_valid", int'(v_a), m_valid[0]); chk("a_wrap", int'(w_a), m_wrap[0]);
        chk("a_err", int'(er_a), m_err[0]);
        chk("b_out", int'(o_b), m_out[1]);   chk("b_cur", int'(c_b), m_sel[1]);
        chk("b_valid", int'(v_b), m_valid[1]); chk("b_wrap", int'(w_b), m_wrap[1]);
        chk("b_err", int'(er_b), m_err[1]);
        chk("c_out", int'(o_c), m_out[2]);   chk("c_cur", int'(c_c), m_sel[2]);
        chk("c_valid", int'(v_c), m_valid[2]); chk("c_wrap", int'(w_c), m_wrap[2]);
        chk("c_err", int'(er_c), m_err[2]);
    endtask

    task automatic cycle();
        @(posedge clk);
        for (int j = 0; j < 3; j++) model_step(j);
        #1;
        cmp_models();
    endtask

    task automatic reset_dut();
        rst = 1; en = 0; md = 0; ld = 0; sel = 0;
        cycle();
        rst = 0;
    endtask

    task automatic scan_cycles(input int k);
        md = 1; en = 1; ld = 0;
        for (int i = 0; i < k; i++) begin
            e = 16'($urandom);
            cycle();
        end
    endtask

    typedef struct {
        bit          rst, en, md, ld;
        logic [3:0]  sel;
        logic [15:0] e;
        bit          o;
        logic [3:0]  cur;
        bit          v, w, er;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int wraps;
        bit held;
        bit exp_bit;
        logic [15:0] ev;

        tbl[0] = '{1, 0, 0, 0, 4'd0,  16'h8001, 0, 4'd0,  0, 0, 0};
        tbl[1] = '{0, 0, 0, 0, 4'd5,  16'hFFFF, 0, 4'd0,  0, 0, 0};
        tbl[2] = '{0, 1, 0, 0, 4'd0,  16'h8001, 1, 4'd0,  1, 0, 0};
        tbl[3] = '{0, 1, 0, 0, 4'd15, 16'h8001, 1, 4'd15, 1, 0, 0};
        tbl[4] = '{0, 1, 0, 0, 4'd7,  16'h8001, 0, 4'd7,  1, 0, 0};
        tbl[5] = '{0, 0, 0, 0, 4'd1,  16'hFFFF, 0, 4'd7,  0, 0, 0};
        tbl[6] = '{0, 1, 0, 0, 4'd1,  16'h4000, 1, 4'd1,  1, 0, 0};
        tbl[7] = '{0, 1, 1, 0, 4'd9,  16'h4000, 1, 4'd1,  1, 0, 0};

        rst = 1; en = 0; md = 0; ld = 0; sel = 0; e = 0;
        model_reset();

        // Table vectors against dut_a.
        for (int i = 0; i < 8; i++) begin
            rst = tbl[i].rst; en = tbl[i].en; md = tbl[i].md; ld = tbl[i].ld;
            sel = tbl[i].sel; e = tbl[i].e;
            cycle();
            chk($sformatf("tbl%0d_out", i), int'(o_a), int'(tbl[i].o));
            chk($sformatf("tbl%0d_cur", i), int'(c_a), int'(tbl[i].cur));
            chk($sformatf("tbl%0d_valid", i), int'(v_a), int'(tbl[i].v));
            chk($sformatf("tbl%0d_wrap", i), int'(w_a), int'(tbl[i].w));
            chk($sformatf("tbl%0d_err", i), int'(er_a), int'(tbl[i].er));
        end

        // Full scan: 4 cycles per channel, single wrap at 15 -> 0.
        reset_dut();
        md = 1; en = 1; ld = 0; wraps = 0;
        for (int i = 1; i <= 64; i++) begin
            e = 16'($urandom);
            cycle();
            chk("scan_cur", int'(c_a), (i / 4) % 16);
            chk("scan_wrap", int'(w_a), (i == 64) ? 1 : 0);
            if (w_a) wraps++;
        end
        chk("scan_wrap_count", wraps, 1);

        // Load at the last dwell cycle overrides the step.
        reset_dut();
        scan_cycles(23);
        chk("ld_pre_cur", int'(c_a), 5);
        ld = 1; sel = 4'd9;
        cycle();
        chk("ld_cur", int'(c_a), 9);
        chk("ld_wrap", int'(w_a), 0);
        ld = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("ld_hold_cur", int'(c_a), 9);
        end
        cycle();
        chk("ld_next_cur", int'(c_a), 10);

        // Enable gap freezes pointer, out and dwell position.
        reset_dut();
        scan_cycles(9);
        chk("gap_pre_cur", int'(c_a), 2);
        held = o_a;
        en = 0;
        for (int i = 0; i < 3; i++) begin
            e = 16'($urandom);
            cycle();
            chk("gap_cur", int'(c_a), 2);
            chk("gap_out", int'(o_a), int'(held));
            chk("gap_valid", int'(v_a), 0);
        end
        en = 1;
        cycle(); chk("gap_resume1", int'(c_a), 2); chk("gap_valid1", int'(v_a), 1);
        cycle(); chk("gap_resume2", int'(c_a), 2);
        cycle(); chk("gap_resume3", int'(c_a), 3);

        // Ten-input configuration: out-of-range select and 9 -> 0 wrap.
        reset_dut();
        md = 0; en = 1; sel = 4'd12; e = 16'hFFFF;
        cycle();
        chk("n10_bad_out", int'(o_b), 0);
        chk("n10_bad_err", int'(er_b), 1);
        chk("n10_bad_cur", int'(c_b), 12);
        ev = 16'($urandom); e = ev; sel = 4'd3;
        exp_bit = ev[6];
        cycle();
        chk("n10_ok_err", int'(er_b), 0);
        chk("n10_ok_out", int'(o_b), int'(exp_bit));
        sel = 4'd9;
        cycle();
        md = 1;
        cycle();
        chk("n10_dwell_cur", int'(c_b), 9);
        chk("n10_dwell_wrap", int'(w_b), 0);
        cycle();
        chk("n10_wrap_cur", int'(c_b), 0);
        chk("n10_wrap", int'(w_b), 1);

        // Reset mid-scan overrides enable/mode; IDLE holds until enabled.
        reset_dut();
        scan_cycles(44);
        chk("rst_pre_cur", int'(c_a), 11);
        rst = 1;
        cycle();
        rst = 0; en = 0;
        chk("rst_cur", int'(c_a), 0);
        chk("rst_out", int'(o_a), 0);
        chk("rst_valid", int'(v_a), 0);
        chk("rst_err", int'(er_a), 0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("idle_cur", int'(c_a), 0);
            chk("idle_valid", int'(v_a), 0);
        end
        en = 1; md = 1;
        cycle();
        chk("restart_cur", int'(c_a), 0);
        chk("restart_valid", int'(v_a), 1);

        // Random traffic against the models.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            en  = ($urandom_range(0, 9) < 8);
            md  = ($urandom_range(0, 3) != 0);
            ld  = ($urandom_range(0, 7) == 0);
            sel = 4'($urandom);
            e   = 16'($urandom);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/modulo_mux_scan.md
MODULO_MUX_SCAN -- requirements
Module: modulo_mux_scan

Interface
REQ-001 Parameter N_INPUTS, default 16, number of data inputs (legal range 2..64).
REQ-002 Parameter SEL_W, default 4, select width; SHALL equal ceil(log2(N_INPUTS)).
REQ-003 Parameter DWELL, default 4, clock cycles each channel is held in scan mode (legal range 1..255).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 input_e  input  N_INPUTS  data inputs.
REQ-007 input_sel  input  SEL_W  manual select / scan load value.
REQ-008 mode  input  1  0 = manual, 1 = scan.
REQ-009 enable  input  1  1 = advance/sample, 0 = freeze all state.
REQ-010 load  input  1  scan mode: load input_sel into the channel pointer.
REQ-011 out  output  1  registered selected data bit.
REQ-012 cur_sel  output  SEL_W  channel pointer currently driving out.
REQ-013 valid  output  1  out holds a sample taken on the previous cycle.
REQ-014 wrap  output  1  one-cycle pulse on scan wrap-around.
REQ-015 sel_err  output  1  registered flag: selected index >= N_INPUTS.

Function
REQ-016 Select mapping SHALL be inverted: index k selects input_e[N_INPUTS-1-k] (k=0 -> input_e[15] at default).
REQ-017 States SHALL be IDLE, MANUAL, SCAN.
REQ-018 IDLE: out, cur_sel, valid, wrap, sel_err held at reset values; exit on first cycle with enable=1 to MANUAL (mode=0) or SCAN (mode=1).
REQ-019 MANUAL or SCAN with enable=1: next state follows mode every cycle; mode change is honoured on the same edge.
REQ-020 Any state with enable=0: out, cur_sel, dwell counter, sel_err held; valid and wrap driven 0 next cycle; state unchanged.
REQ-021 MANUAL, enable=1: cur_sel <= input_sel; out <= mapped input_e bit of input_sel; latency exactly 1 cycle.
REQ-022 SCAN, enable=1, load=0: out <= mapped bit of current cur_sel every cycle; dwell counter increments; when it reaches DWELL-1 it clears and cur_sel increments.
REQ-023 Scan wrap: cur_sel at N_INPUTS-1 advancing SHALL go to 0 (not 2^SEL_W-1) and assert wrap for exactly that cycle.
REQ-024 SCAN, load=1: cur_sel <= input_sel, dwell counter <= 0, out sampled from input_sel same edge; load overrides a simultaneous dwell step; no wrap pulse.
REQ-025 Entering SCAN from MANUAL SHALL continue from the existing cur_sel with dwell counter cleared.
REQ-026 Index >= N_INPUTS (non-power-of-2 N): out <= 0, sel_err <= 1 on that edge; sel_err clears on the next valid-index sample.
REQ-027 valid SHALL be 1 on the cycle after every enabled sample in MANUAL or SCAN, else 0.
REQ-028 DWELL=1: cur_sel advances every enabled scan cycle.

Reset
REQ-029 reset=1 at a rising edge SHALL force state IDLE, out=0, cur_sel=0, dwell counter=0, valid=0, wrap=0, sel_err=0, overriding enable, load and mode.
REQ-030 Reset asserted mid-scan SHALL abort the dwell; after release scanning restarts at cur_sel=0 only once enable=1.

Verification
REQ-031 Reset, mode=0, enable=1, input_e=16'h8001, input_sel=0 -> next cycle out=1, cur_sel=0, valid=1; input_sel=15 -> out=1; input_sel=7 -> out=0.
REQ-032 mode=1, DWELL=4, enable=1 held 64 cycles -> cur_sel steps 0..15, 4 cycles each, wrap pulses once when 15 -> 0.
REQ-033 Scan at cur_sel=5, dwell count 3, load=1 with input_sel=9 -> cur_sel=9, dwell=0, no increment, wrap=0.
REQ-034 Scan, enable dropped 3 cycles at cur_sel=2 -> out/cur_sel frozen, valid=0; resumes same dwell position.
REQ-035 N_INPUTS=10, SEL_W=4, manual input_sel=12 -> out=0, sel_err=1; input_sel=3 -> sel_err=0; scan wraps 9 -> 0.
REQ-036 Reset pulsed mid-scan at cur_sel=11 -> all outputs zero next cycle, state IDLE until enable=1.
